// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
//
// add_sub: BitWidth-generic adder/subtractor.
//   a, b       operands
//   sub1_add0  1 = a - b (two's complement), 0 = a + b
//   sum        result, modulo 2^Width
//   cout       carry out; when subtracting, 1 means no borrow (a >= b unsigned)
//
// seq_divider: one quotient bit per cycle, start/done handshake.
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request, sampled only while ready is high
//   is_signed  1 = DIV/REM, 0 = DIVU/REMU, sampled with start
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   ready      high only while idle and able to accept start
//   done       one-cycle pulse, quotient/remainder valid
//   quotient   registered quotient, held until the next accepted start
//   remainder  registered remainder, held until the next accepted start

module add_sub #(
  parameter int Width = 33
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             sub1_add0,
  output logic [Width-1:0] sum,
  output logic             cout
);

  // Subtraction is a + ~b + 1; the carry-in rides in as the low bit.
  assign {cout, sum} = {1'b0, a}
                     + {1'b0, b ^ {Width{sub1_add0}}}
                     + {{Width{1'b0}}, sub1_add0};

endmodule

module seq_divider #(
  parameter int BitWidth = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic [BitWidth-1:0] dividend,
  input  logic [BitWidth-1:0] divisor,
  output logic                ready,
  output logic                done,
  output logic [BitWidth-1:0] quotient,
  output logic [BitWidth-1:0] remainder
);

  localparam int CntW = $clog2(BitWidth);
  localparam logic [CntW-1:0] LastIter = CntW'(BitWidth - 1);
  localparam logic [BitWidth-1:0] MostNeg = {1'b1, {(BitWidth-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CntW-1:0]     iter_cnt;
  // work_q starts as the dividend magnitude; each cycle its MSB moves into
  // the partial remainder and a quotient bit enters at the bottom, so after
  // BitWidth cycles it holds the unsigned quotient.
  logic [BitWidth-1:0] work_q;
  logic [BitWidth-1:0] part_rem;
  logic [BitWidth-1:0] dsr_mag;
  logic                neg_quo;
  logic                neg_rem;

  // Operand preparation for an accepted start.
  logic                dvd_neg;
  logic                dsr_neg;
  logic [BitWidth-1:0] dvd_abs;
  logic [BitWidth-1:0] dsr_abs;
  logic                is_div_zero;
  logic                is_overflow;

  assign dvd_neg     = is_signed & dividend[BitWidth-1];
  assign dsr_neg     = is_signed & divisor[BitWidth-1];
  // Negating the most negative value gives 2^(BitWidth-1), which is still
  // the correct magnitude when read as unsigned.
  assign dvd_abs     = dvd_neg ? -dividend : dividend;
  assign dsr_abs     = dsr_neg ? -divisor : divisor;
  assign is_div_zero = (divisor == '0);
  assign is_overflow = is_signed && (dividend == MostNeg) && (divisor == '1);

  // One restoring step. The shifted partial can need BitWidth+1 bits because
  // the previous partial may be as large as divisor-1.
  logic [BitWidth:0]   shifted;
  logic [BitWidth:0]   trial;
  logic                no_borrow;
  logic [BitWidth-1:0] next_part;
  logic [BitWidth-1:0] next_q;
  logic [BitWidth-1:0] final_quo;
  logic [BitWidth-1:0] final_rem;
  logic                unused_trial_msb;

  assign shifted = {part_rem, work_q[BitWidth-1]};

  add_sub #(
    .Width(BitWidth + 1)
  ) u_trial_sub (
    .a        (shifted),
    .b        ({1'b0, dsr_mag}),
    .sub1_add0(1'b1),
    .sum      (trial),
    .cout     (no_borrow)
  );

  // A successful trial leaves a value below the divisor, so its top bit is
  // always zero; when the trial fails the shifted top bit is zero as well.
  assign unused_trial_msb = trial[BitWidth];
  assign next_part = no_borrow ? trial[BitWidth-1:0] : shifted[BitWidth-1:0];
  assign next_q    = {work_q[BitWidth-2:0], no_borrow};

  // Sign fix-up used on the last iteration edge: quotient is negative when
  // operand signs differ, remainder follows the dividend's sign.
  assign final_quo = neg_quo ? -next_q : next_q;
  assign final_rem = neg_rem ? -next_part : next_part;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      iter_cnt  <= '0;
      work_q    <= '0;
      part_rem  <= '0;
      dsr_mag   <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          if (start) begin
            ready <= 1'b0;
            if (is_div_zero) begin
              // RISC-V divide by zero: all-ones quotient, dividend remainder.
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
              state     <= DONE;
            end else if (is_overflow) begin
              // Signed overflow: quotient wraps to the dividend, no remainder.
              quotient  <= dividend;
              remainder <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              work_q   <= dvd_abs;
              dsr_mag  <= dsr_abs;
              part_rem <= '0;
              iter_cnt <= '0;
              neg_quo  <= dvd_neg ^ dsr_neg;
              neg_rem  <= dvd_neg;
              state    <= RUN;
            end
          end
        end

        RUN: begin
          work_q   <= next_q;
          part_rem <= next_part;
          iter_cnt <= iter_cnt + CntW'(1);
          if (iter_cnt == LastIter) begin
            quotient  <= final_quo;
            remainder <= final_rem;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider

module tb_seq_divider;

  localparam int W = 32;
  localparam int MaxWait = W + 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.BitWidth(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Reference model with the RISC-V special cases; SV signed division
  // truncates toward zero and the remainder takes the dividend's sign.
  function automatic exp_t ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = '0; e.lat = 1;
    end else if (sgn) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
      e.lat = W + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = W + 1;
    end
    return e;
  endfunction

  // Call at a negedge while the DUT is idle: presents the request, pushes
  // the expected result, then scrambles operands after the accepting edge.
  task automatic start_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    sb.push_back(ref_div(sgn, a, b));
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = ~a;
    divisor   = b + 32'd1;
    is_signed = ~sgn;
  endtask

  // Counts negedges after the accepting edge until done; optionally pulses
  // start with other operands at negedge number busy_at.
  task automatic wait_done(input int busy_at, output int lat, output bit seen, output bit ready_bad);
    lat = 0; seen = 1'b0; ready_bad = 1'b0;
    while (!seen && lat < MaxWait) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (lat == busy_at) begin
        start = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'd3; is_signed = 1'b0;
      end
      if (done) seen = 1'b1;
      else if (ready) ready_bad = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_unsigned();
    exp_t e; int lat; bit seen, rb;
    @(negedge clk);
    start_op(1'b0, 32'd100, 32'd7);
    wait_done(-1, lat, seen, rb);
    e = sb.pop_front();
    n_checks++; if (!seen) begin n_fail++; $display("FAIL unsigned_done: no done in %0d cycles", MaxWait); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL unsigned_latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (rb) begin n_fail++; $display("FAIL unsigned_ready_busy: ready rose before done, want low"); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL unsigned_ready_done: got %b want 0", ready); end
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL unsigned_q: got %h want %h", quotient, e.q); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL unsigned_r: got %h want %h", remainder, e.r); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL unsigned_done_pulse: got %b want 0", done); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL unsigned_ready_idle: got %b want 1", ready); end
    repeat (3) @(negedge clk);
    n_checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin
      n_fail++; $display("FAIL unsigned_hold: got %h/%h want 0000000e/00000002", quotient, remainder);
    end
  endtask

  // Shared body for small directed tables: signed, divide-by-zero, overflow.
  task automatic run_table(input string name, input bit sgn[], input logic [W-1:0] a[], input logic [W-1:0] b[]);
    exp_t e; int lat; bit seen, rb;
    for (int i = 0; i < a.size(); i++) begin
      @(negedge clk);
      start_op(sgn[i], a[i], b[i]);
      wait_done(-1, lat, seen, rb);
      e = sb.pop_front();
      n_checks++; if (!seen) begin n_fail++; $display("FAIL %s_done[%0d]: no done in %0d cycles", name, i, MaxWait); end
      n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, lat, e.lat); end
      n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL %s_q[%0d]: got %h want %h", name, i, quotient, e.q); end
      n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL %s_r[%0d]: got %h want %h", name, i, remainder, e.r); end
    end
  endtask

  task automatic test_signed();
    bit s[] = '{1'b1, 1'b0};
    logic [W-1:0] a[] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [W-1:0] b[] = '{32'd2, 32'd2};
    run_table("signed", s, a, b);
    n_checks++; if (quotient !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL signed_unsigned_q_const: got %h want 7ffffffc", quotient); end
  endtask

  task automatic test_div_zero();
    bit s[] = '{1'b1, 1'b0};
    logic [W-1:0] a[] = '{32'h1234_5678, 32'h1234_5678};
    logic [W-1:0] b[] = '{32'd0, 32'd0};
    run_table("divzero", s, a, b);
  endtask

  task automatic test_overflow();
    bit s[] = '{1'b1, 1'b0};
    logic [W-1:0] a[] = '{32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] b[] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_table("overflow", s, a, b);
  endtask

  task automatic test_busy();
    exp_t e; int lat; bit seen, rb;
    @(negedge clk);
    start_op(1'b0, 32'hFFFF_FFFF, 32'd10);
    wait_done(5, lat, seen, rb);
    e = sb.pop_front();
    n_checks++; if (!seen) begin n_fail++; $display("FAIL busy_done: no done in %0d cycles", MaxWait); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL busy_latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL busy_result: got %h/%h want %h/%h", quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL busy_no_queue: done=%b ready=%b want 0/1", done, ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat; bit seen, rb, early;
    @(negedge clk);
    start_op(1'b1, 32'hFFFF_F000, 32'd7);
    early = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) early = 1'b1;
    end
    void'(sb.pop_front());
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (early) begin n_fail++; $display("FAIL rstmid_early_done: done seen before reset, want none"); end
    n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: ready=%b done=%b want 1/0", ready, done);
    end
    n_checks++; if (quotient !== '0 || remainder !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h/%h want 0/0", quotient, remainder);
    end
    rst = 1'b0;
    start_op(1'b1, 32'd12345, 32'hFFFF_FFF6);
    wait_done(-1, lat, seen, rb);
    e = sb.pop_front();
    n_checks++; if (!seen || lat != e.lat) begin
      n_fail++; $display("FAIL rstmid_restart_latency: seen=%b got %0d want %0d", seen, lat, e.lat);
    end
    n_checks++; if (quotient !== e.q || remainder !== e.r) begin
      n_fail++; $display("FAIL rstmid_restart_result: got %h/%h want %h/%h", quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit seen, rb;
    @(negedge clk);
    start_op(1'b1, 32'h8000_0001, 32'd3);
    for (int i = 0; i < 3; i++) begin
      wait_done(-1, lat, seen, rb);
      e = sb.pop_front();
      n_checks++; if (!seen || lat != e.lat) begin
        n_fail++; $display("FAIL b2b_latency[%0d]: seen=%b got %0d want %0d", i, seen, lat, e.lat);
      end
      n_checks++; if (quotient !== e.q || remainder !== e.r) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got %h/%h want %h/%h", i, quotient, remainder, e.q, e.r);
      end
      @(negedge clk);
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ready); end
      if (i == 0) start_op(1'b0, 32'd7, 32'd0);
      else if (i == 1) start_op(1'b0, 32'hCAFE_F00D, 32'h0000_1234);
    end
  endtask

  task automatic test_random();
    exp_t e; int lat; bit seen, rb, sgn;
    logic [W-1:0] a, b;
    int sel;
    for (int n = 0; n < 1000; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      @(negedge clk);
      start_op(sgn, a, b);
      wait_done(-1, lat, seen, rb);
      e = sb.pop_front();
      n_checks++; if (!seen || lat != e.lat) begin
        n_fail++; $display("FAIL rand_latency[%0d]: seen=%b got %0d want %0d", n, seen, lat, e.lat);
      end
      n_checks++; if (quotient !== e.q) begin
        n_fail++; $display("FAIL rand_q[%0d]: s=%b %h/%h got %h want %h", n, sgn, a, b, quotient, e.q);
      end
      n_checks++; if (remainder !== e.r) begin
        n_fail++; $display("FAIL rand_r[%0d]: s=%b %h/%h got %h want %h", n, sgn, a, b, remainder, e.r);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
